// File: rtl/sync_debounce_if.sv
// sync_debounce_if: signal bundle between a debounced-input consumer and sync_debounce.
// The master side drives the raw level and controls; the slave side returns the filtered results.
interface sync_debounce_if #(
    parameter int CNT_WIDTH = 16,
    parameter int EVT_WIDTH = 16
);
    logic                 s_in;
    logic [CNT_WIDTH-1:0] debounce_cycles;
    logic                 evt_clr;
    logic                 level;
    logic                 rise;
    logic                 fall;
    logic [EVT_WIDTH-1:0] evt_cnt;

    modport master (
        output s_in, debounce_cycles, evt_clr,
        input  level, rise, fall, evt_cnt
    );

    modport slave (
        input  s_in, debounce_cycles, evt_clr,
        output level, rise, fall, evt_cnt
    );
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: persistence filter on a synchronized 1-bit level.
// Produces the qualified level, one-cycle rise/fall strobes and a saturating transition count.
module sync_debounce #(
    parameter bit INIT      = 1'b0,
    parameter int CNT_WIDTH = 16,
    parameter int EVT_WIDTH = 16
) (
    input logic            clk,
    input logic            rst_n,
    sync_debounce_if.slave bus
);
    typedef enum logic {STABLE, CHECK} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic [EVT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
    logic                 differ, commit, pending;

    // Threshold is compared live, so lowering it mid-check commits on the next differing edge.
    always_comb begin
        differ    = bus.s_in != level_q;
        commit    = differ && (state_q == STABLE ? bus.debounce_cycles == '0
                                                 : cnt_q >= bus.debounce_cycles);
        pending   = differ && !commit;
        state_d   = pending ? CHECK : STABLE;
        cnt_d     = pending ? (state_q == STABLE ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1)) : '0;
        level_d   = level_q ^ commit;
        rise_d    = commit && !level_q;
        fall_d    = commit && level_q;
        evt_cnt_d = bus.evt_clr ? '0
                  : (commit && evt_cnt_q != '1) ? evt_cnt_q + EVT_WIDTH'(1) : evt_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STABLE;
            cnt_q     <= '0;
            level_q   <= INIT;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign bus.level   = level_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.evt_cnt = evt_cnt_q;
endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed and model-based checks of sync_debounce.
// u0: INIT=0/EVT=16, u1: INIT=0/EVT=3 (saturation), u2: INIT=1 (async reset case).
module tb_sync_debounce;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_in = 1'b0;
    logic        evt_clr = 1'b0;
    logic [15:0] dc = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sync_debounce_if #(.CNT_WIDTH(16), .EVT_WIDTH(16)) bus0 ();
    sync_debounce_if #(.CNT_WIDTH(16), .EVT_WIDTH(3))  bus1 ();
    sync_debounce_if #(.CNT_WIDTH(16), .EVT_WIDTH(16)) bus2 ();

    assign bus0.s_in = s_in; assign bus0.debounce_cycles = dc; assign bus0.evt_clr = evt_clr;
    assign bus1.s_in = s_in; assign bus1.debounce_cycles = dc; assign bus1.evt_clr = evt_clr;
    assign bus2.s_in = s_in; assign bus2.debounce_cycles = dc; assign bus2.evt_clr = evt_clr;

    sync_debounce #(.INIT(1'b0), .CNT_WIDTH(16), .EVT_WIDTH(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    sync_debounce #(.INIT(1'b0), .CNT_WIDTH(16), .EVT_WIDTH(3))  u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    sync_debounce #(.INIT(1'b1), .CNT_WIDTH(16), .EVT_WIDTH(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic s);
        rst_n = 1'b0; s_in = s; evt_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_in = 1'b0; dc = 16'd0; evt_clr = 1'b0;
        tick(); tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt} !== 19'd0) begin
            errors++; $display("FAIL reset_u0 got lvl=%b r=%b f=%b evt=%0d exp all 0", bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt);
        end
        checks++;
        if (bus2.level !== 1'b1) begin
            errors++; $display("FAIL reset_u2_init got %b exp 1", bus2.level);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt} !== 19'd0) begin
                errors++; $display("FAIL idle_cycle%0d got lvl=%b r=%b f=%b evt=%0d exp all 0", i, bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt);
            end
        end
        s_in = 1'b1;
        tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt} !== {3'b110, 16'd1}) begin
            errors++; $display("FAIL dc0_rise got lvl=%b r=%b f=%b evt=%0d exp 1 1 0 1", bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt);
        end
        tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.fall} !== 3'b100) begin
            errors++; $display("FAIL dc0_strobe_one_cycle got lvl=%b r=%b f=%b exp 1 0 0", bus0.level, bus0.rise, bus0.fall);
        end
        s_in = 1'b0;
        tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt} !== {3'b001, 16'd2}) begin
            errors++; $display("FAIL dc0_fall got lvl=%b r=%b f=%b evt=%0d exp 0 0 1 2", bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt);
        end
    endtask

    task automatic test_glitch();
        do_reset(1'b0);
        dc = 16'd4;
        for (int w = 1; w <= 4; w++) begin
            s_in = 1'b1;
            for (int i = 0; i < w + 10; i++) begin
                if (i == w) s_in = 1'b0;
                tick();
                checks++;
                if ({bus0.level, bus0.rise, bus0.fall} !== 3'b000) begin
                    errors++; $display("FAIL glitch_w%0d_c%0d got lvl=%b r=%b f=%b exp 0 0 0", w, i, bus0.level, bus0.rise, bus0.fall);
                end
            end
        end
        checks++;
        if (bus0.evt_cnt !== 16'd0) begin
            errors++; $display("FAIL glitch_evt got %0d exp 0", bus0.evt_cnt);
        end
        s_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({bus0.level, bus0.rise} !== 2'b00) begin
            errors++; $display("FAIL pulse5_early got lvl=%b r=%b exp 0 0", bus0.level, bus0.rise);
        end
        tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.fall} !== 3'b110) begin
            errors++; $display("FAIL pulse5_rise got lvl=%b r=%b f=%b exp 1 1 0", bus0.level, bus0.rise, bus0.fall);
        end
        s_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.fall} !== 3'b100) begin
            errors++; $display("FAIL pulse5_fall_early got lvl=%b r=%b f=%b exp 1 0 0", bus0.level, bus0.rise, bus0.fall);
        end
        tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt} !== {3'b001, 16'd2}) begin
            errors++; $display("FAIL pulse5_fall got lvl=%b r=%b f=%b evt=%0d exp 0 0 1 2", bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt);
        end
    endtask

    task automatic test_live_threshold();
        do_reset(1'b0);
        dc = 16'd100;
        s_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if ({bus0.level, bus0.rise} !== 2'b00) begin
            errors++; $display("FAIL live_wait got lvl=%b r=%b exp 0 0", bus0.level, bus0.rise);
        end
        dc = 16'd5;
        tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt} !== {3'b110, 16'd1}) begin
            errors++; $display("FAIL live_commit got lvl=%b r=%b f=%b evt=%0d exp 1 1 0 1", bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt);
        end
        tick();
        checks++;
        if ({bus0.level, bus0.rise, bus0.evt_cnt} !== {2'b10, 16'd1}) begin
            errors++; $display("FAIL live_single got lvl=%b r=%b evt=%0d exp 1 0 1", bus0.level, bus0.rise, bus0.evt_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset(1'b0);
        dc = 16'd0;
        for (int i = 1; i <= 9; i++) begin
            s_in = ~s_in;
            tick();
            checks++;
            if (bus1.evt_cnt !== 3'((i > 7) ? 7 : i)) begin
                errors++; $display("FAIL sat_toggle%0d got %0d exp %0d", i, bus1.evt_cnt, (i > 7) ? 7 : i);
            end
        end
        s_in = ~s_in;
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        checks++;
        if ({bus1.level, bus1.rise, bus1.fall, bus1.evt_cnt} !== {3'b001, 3'd0}) begin
            errors++; $display("FAIL clr_wins got lvl=%b r=%b f=%b evt=%0d exp 0 0 1 0", bus1.level, bus1.rise, bus1.fall, bus1.evt_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        dc = 16'd8;
        s_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus2.level, bus2.fall} !== 2'b10) begin
            errors++; $display("FAIL async_rst got lvl=%b f=%b exp 1 0", bus2.level, bus2.fall);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if ({bus2.level, bus2.fall} !== 2'b10) begin
            errors++; $display("FAIL async_requal got lvl=%b f=%b exp 1 0", bus2.level, bus2.fall);
        end
        tick();
        checks++;
        if ({bus2.level, bus2.rise, bus2.fall} !== 3'b001) begin
            errors++; $display("FAIL async_fall got lvl=%b r=%b f=%b exp 0 0 1", bus2.level, bus2.rise, bus2.fall);
        end
    endtask

    task automatic test_random();
        logic        m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_chk = 1'b0, commit;
        int unsigned m_cnt = 0, m_evt = 0;
        int          dc_set[4] = '{0, 1, 2, 7};
        int          reported = 0;
        do_reset(1'b0);
        for (int c = 0; c < 20000; c++) begin
            if (c % 400 == 0) dc = 16'(dc_set[$urandom_range(0, 3)]);
            if ($urandom_range(0, 2) == 0) s_in = ~s_in;
            evt_clr = ($urandom_range(0, 199) == 0);
            commit = 1'b0;
            if (s_in == m_level) begin
                m_chk = 1'b0; m_cnt = 0;
            end else if (!m_chk) begin
                if (dc == 0) commit = 1'b1;
                else begin m_chk = 1'b1; m_cnt = 1; end
            end else if (m_cnt >= dc) commit = 1'b1;
            else m_cnt++;
            if (commit) begin m_chk = 1'b0; m_cnt = 0; m_level = ~m_level; end
            m_rise = commit && m_level;
            m_fall = commit && !m_level;
            if (evt_clr) m_evt = 0;
            else if (commit && m_evt < 65535) m_evt++;
            tick();
            checks++;
            if ({bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt} !== {m_level, m_rise, m_fall, 16'(m_evt)}
                || (bus0.rise && bus0.fall)) begin
                errors++;
                if (reported++ < 10)
                    $display("FAIL random_c%0d got lvl=%b r=%b f=%b evt=%0d exp %b %b %b %0d",
                             c, bus0.level, bus0.rise, bus0.fall, bus0.evt_cnt, m_level, m_rise, m_fall, m_evt);
            end
        end
        evt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_live_threshold();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
